// File: rtl/coin_ctrl_if.sv
// Coin controller bus: sensor/button levels and price in, status and
// pulses out. The controller uses the slave view, the stimulus side the
// master view.
interface coin_ctrl_if;
    logic       coin_half;
    logic       coin_one;
    logic       confirm;
    logic       cancel;
    logic [7:0] price;
    logic       occupy;
    logic [7:0] coin_value;
    logic [7:0] change_value;
    logic       vend;
    logic       refund;
    logic       reject;

    modport master (
        output coin_half, coin_one, confirm, cancel, price,
        input  occupy, coin_value, change_value, vend, refund, reject
    );

    modport slave (
        input  coin_half, coin_one, confirm, cancel, price,
        output occupy, coin_value, change_value, vend, refund, reject
    );
endinterface

// File: rtl/coin_ctrl.sv
// Vending coin controller: accumulates half-unit credit from two coin
// sensors, vends on confirm when credit covers the price, refunds on
// cancel or after an idle timeout. All outputs are registered and
// reflect the state being entered on each clk_n edge.
module coin_ctrl #(
    parameter int MAX_VALUE = 39,
    parameter int TIMEOUT   = 1000
) (
    input  logic       clk_n,
    input  logic       rst,
    coin_ctrl_if.slave bus
);
    localparam logic [8:0]  MAX_V   = 9'(MAX_VALUE);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    state_t      state_q;
    logic        half_prev_q;
    logic        one_prev_q;
    logic        confirm_prev_q;
    logic        cancel_prev_q;
    logic        armed_q;
    logic [15:0] timer_q;
    logic        occupy_q;
    logic [7:0]  coin_value_q;
    logic [7:0]  change_value_q;
    logic        vend_q;
    logic        refund_q;
    logic        reject_q;

    logic        half_edge;
    logic        one_edge;
    logic        confirm_edge;
    logic        cancel_edge;
    logic        coin_edge;
    logic [1:0]  coin_add;
    logic [8:0]  coin_sum;
    logic        coin_fits;
    logic [7:0]  coin_value_d;
    logic        price_met;
    logic [7:0]  change_value_d;
    logic        timed_out;
    logic [15:0] timer_d;

    // Edge detection and the arithmetic the FSM needs this cycle.
    // armed_q masks edges on the first edge after reset, so a level that
    // was already high during reset is not mistaken for a fresh press.
    always_comb begin
        half_edge      = armed_q & bus.coin_half & ~half_prev_q;
        one_edge       = armed_q & bus.coin_one  & ~one_prev_q;
        confirm_edge   = armed_q & bus.confirm   & ~confirm_prev_q;
        cancel_edge    = armed_q & bus.cancel    & ~cancel_prev_q;
        coin_add       = {one_edge, half_edge};
        coin_edge      = |coin_add;
        coin_sum       = {1'b0, coin_value_q} + {7'd0, coin_add};
        coin_fits      = (coin_sum <= MAX_V);
        coin_value_d   = coin_sum[7:0];
        price_met      = (coin_value_q >= bus.price);
        change_value_d = coin_value_q - bus.price;
        timed_out      = (timer_q == TO_LAST);
        timer_d        = timer_q + 16'd1;
    end

    // Previous-sample registers for the four edge detectors.
    always_ff @(posedge clk_n) begin
        if (!rst) begin
            half_prev_q    <= 1'b0;
            one_prev_q     <= 1'b0;
            confirm_prev_q <= 1'b0;
            cancel_prev_q  <= 1'b0;
            armed_q        <= 1'b0;
        end else begin
            half_prev_q    <= bus.coin_half;
            one_prev_q     <= bus.coin_one;
            confirm_prev_q <= bus.confirm;
            cancel_prev_q  <= bus.cancel;
            armed_q        <= 1'b1;
        end
    end

    // Transaction FSM with registered outputs; pulses default low each cycle.
    always_ff @(posedge clk_n) begin
        if (!rst) begin
            state_q        <= IDLE;
            timer_q        <= 16'd0;
            occupy_q       <= 1'b0;
            coin_value_q   <= 8'd0;
            change_value_q <= 8'd0;
            vend_q         <= 1'b0;
            refund_q       <= 1'b0;
            reject_q       <= 1'b0;
        end else begin
            vend_q   <= 1'b0;
            refund_q <= 1'b0;
            reject_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (coin_edge) begin
                        if (coin_fits) begin
                            state_q      <= COLLECT;
                            coin_value_q <= coin_value_d;
                            occupy_q     <= 1'b1;
                            timer_q      <= 16'd0;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (cancel_edge) begin
                        state_q        <= REFUND;
                        refund_q       <= 1'b1;
                        change_value_q <= coin_value_q;
                        coin_value_q   <= 8'd0;
                        occupy_q       <= 1'b0;
                    end else if (confirm_edge) begin
                        // An insufficient confirm still counts as activity.
                        timer_q <= 16'd0;
                        if (price_met) begin
                            state_q        <= VEND;
                            vend_q         <= 1'b1;
                            change_value_q <= change_value_d;
                            coin_value_q   <= 8'd0;
                            occupy_q       <= 1'b0;
                        end
                    end else if (coin_edge && coin_fits) begin
                        coin_value_q <= coin_value_d;
                        timer_q      <= 16'd0;
                    end else begin
                        // A refused coin is not activity: the timer keeps running.
                        reject_q <= coin_edge;
                        if (timed_out) begin
                            state_q        <= REFUND;
                            refund_q       <= 1'b1;
                            change_value_q <= coin_value_q;
                            coin_value_q   <= 8'd0;
                            occupy_q       <= 1'b0;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                end
                VEND, REFUND: begin
                    state_q  <= IDLE;
                    reject_q <= coin_edge;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.occupy       = occupy_q;
    assign bus.coin_value   = coin_value_q;
    assign bus.change_value = change_value_q;
    assign bus.vend         = vend_q;
    assign bus.refund       = refund_q;
    assign bus.reject       = reject_q;
endmodule

// File: tb/tb_coin_ctrl.sv
// Bench for coin_ctrl: a credit/transaction model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_coin_ctrl;
    localparam int MAXV = 39;
    localparam int TOUT = 8;

    logic clk_n = 1'b0;
    logic rst   = 1'b0;
    coin_ctrl_if bus ();

    coin_ctrl #(.MAX_VALUE(MAXV), .TIMEOUT(TOUT)) dut (
        .clk_n (clk_n),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_n = ~clk_n;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    int cyc      = 0;
    int m_credit = 0;
    int m_change = 0;
    int m_last   = 0;
    bit m_open = 0, m_closing = 0, m_vend = 0, m_refund = 0, m_reject = 0;
    bit m_armed = 0;
    bit p_half = 0, p_one = 0, p_conf = 0, p_canc = 0;

    always @(posedge clk_n) begin : model
        bit h, o, cf, cn;
        int add, credit_n, change_n, last_n;
        bit open_n, closing_n, vend_n, refund_n, reject_n;
        cyc <= cyc + 1;
        if (!rst) begin
            m_credit <= 0; m_change <= 0; m_last <= 0;
            m_open <= 0; m_closing <= 0;
            m_vend <= 0; m_refund <= 0; m_reject <= 0;
            m_armed <= 0;
            p_half <= 0; p_one <= 0; p_conf <= 0; p_canc <= 0;
        end else begin
            h  = m_armed && bus.coin_half && !p_half;
            o  = m_armed && bus.coin_one  && !p_one;
            cf = m_armed && bus.confirm   && !p_conf;
            cn = m_armed && bus.cancel    && !p_canc;
            add = (h ? 1 : 0) + (o ? 2 : 0);
            credit_n = m_credit; change_n = m_change; last_n = m_last;
            open_n = m_open; closing_n = 0;
            vend_n = 0; refund_n = 0; reject_n = 0;
            if (m_open) begin
                if (cn) begin
                    refund_n = 1; change_n = m_credit; credit_n = 0;
                    open_n = 0; closing_n = 1;
                end else if (cf) begin
                    last_n = cyc;
                    if (m_credit >= int'(bus.price)) begin
                        vend_n = 1; change_n = m_credit - int'(bus.price);
                        credit_n = 0; open_n = 0; closing_n = 1;
                    end
                end else if (add > 0 && m_credit + add <= MAXV) begin
                    credit_n = m_credit + add; last_n = cyc;
                end else begin
                    if (add > 0) reject_n = 1;
                    if (cyc - m_last >= TOUT) begin
                        refund_n = 1; change_n = m_credit; credit_n = 0;
                        open_n = 0; closing_n = 1;
                    end
                end
            end else if (m_closing) begin
                if (add > 0) reject_n = 1;
            end else if (add > 0) begin
                credit_n = add; open_n = 1; last_n = cyc;
            end
            m_credit <= credit_n; m_change <= change_n; m_last <= last_n;
            m_open <= open_n; m_closing <= closing_n;
            m_vend <= vend_n; m_refund <= refund_n; m_reject <= reject_n;
            m_armed <= 1;
            p_half <= bus.coin_half; p_one <= bus.coin_one;
            p_conf <= bus.confirm;   p_canc <= bus.cancel;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        if (act != exp) begin
            n_mis++;
            $display("FAIL cycle %0d %s: got %0d expected %0d", cyc, name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_n) begin
        if (chk_en) begin
            n_vec++;
            cmp("occupy",       int'(bus.occupy),       int'(m_open));
            cmp("coin_value",   int'(bus.coin_value),   m_credit);
            cmp("change_value", int'(bus.change_value), m_change);
            cmp("vend",         int'(bus.vend),         int'(m_vend));
            cmp("refund",       int'(bus.refund),       int'(m_refund));
            cmp("reject",       int'(bus.reject),       int'(m_reject));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check_lit(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL lit %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int s_reject, s_vend, s_refund, s_change, s_coin, s_occupy;

    task automatic coin(input bit h, input bit o);
        bus.coin_half = h; bus.coin_one = o;
        @(negedge clk_n);
        s_reject = int'(bus.reject);
        bus.coin_half = 0; bus.coin_one = 0;
        @(negedge clk_n);
        $display("txn coin half=%0b one=%0b -> coin_value=%0d reject=%0d",
                 h, o, bus.coin_value, s_reject);
    endtask

    task automatic press(input bit do_conf, input bit do_canc);
        bus.confirm = do_conf; bus.cancel = do_canc;
        @(negedge clk_n);
        s_vend = int'(bus.vend); s_refund = int'(bus.refund);
        s_change = int'(bus.change_value); s_coin = int'(bus.coin_value);
        s_occupy = int'(bus.occupy);
        bus.confirm = 0; bus.cancel = 0;
        @(negedge clk_n);
        $display("txn press confirm=%0b cancel=%0b price=%0d -> vend=%0d refund=%0d change=%0d",
                 do_conf, do_canc, bus.price, s_vend, s_refund, s_change);
    endtask

    initial begin
        int k;
        bus.coin_half = 0; bus.coin_one = 0; bus.confirm = 0; bus.cancel = 0;
        bus.price = 8'd7;
        rst = 0;
        repeat (3) @(negedge clk_n);
        chk_en = 1;
        check_lit("reset occupy", int'(bus.occupy), 0);
        check_lit("reset coin_value", int'(bus.coin_value), 0);
        check_lit("reset change_value", int'(bus.change_value), 0);
        rst = 1;
        @(negedge clk_n);

        // Idle ignores confirm/cancel.
        press(1, 1);
        check_lit("idle confirm occupy", s_occupy, 0);

        // one then half -> 2, 3
        coin(0, 1);
        check_lit("first coin occupy", int'(bus.occupy), 1);
        check_lit("first coin value", int'(bus.coin_value), 2);
        coin(1, 0);
        check_lit("second coin value", int'(bus.coin_value), 3);
        press(0, 1);
        check_lit("cancel refund", s_refund, 1);
        check_lit("cancel change", s_change, 3);
        check_lit("refund one cycle", int'(bus.refund), 0);

        // Credit ceiling.
        for (int i = 0; i < 19; i++) coin(0, 1);
        check_lit("credit 38", int'(bus.coin_value), 38);
        coin(0, 1);
        check_lit("over max reject", s_reject, 1);
        check_lit("over max unchanged", int'(bus.coin_value), 38);
        coin(1, 0);
        check_lit("fill to 39", int'(bus.coin_value), 39);
        coin(1, 0);
        check_lit("at max reject", s_reject, 1);
        press(0, 1);
        check_lit("refund 39", s_change, 39);

        // Vend with change.
        for (int i = 0; i < 5; i++) coin(0, 1);
        bus.price = 8'd7;
        press(1, 0);
        check_lit("vend pulse", s_vend, 1);
        check_lit("vend change", s_change, 3);
        check_lit("vend coin cleared", s_coin, 0);
        check_lit("vend occupy", s_occupy, 0);
        check_lit("vend one cycle", int'(bus.vend), 0);
        check_lit("change held", int'(bus.change_value), 3);

        // Insufficient confirm, then cancel.
        coin(0, 1); coin(0, 1);
        press(1, 0);
        check_lit("short vend", s_vend, 0);
        check_lit("short still open", s_occupy, 1);
        check_lit("short credit kept", s_coin, 4);
        press(0, 1);
        check_lit("short refund change", s_change, 4);

        // Both coins at once, then confirm+cancel together.
        coin(1, 1);
        check_lit("both coins", int'(bus.coin_value), 3);
        bus.price = 8'd1;
        press(1, 1);
        check_lit("cancel wins refund", s_refund, 1);
        check_lit("cancel wins no vend", s_vend, 0);

        // Idle timeout: refund on the TOUT-th edge after the coin.
        coin(1, 0);
        k = 0;
        while (k < 20) begin
            @(negedge clk_n);
            k++;
            if (bus.refund) break;
        end
        check_lit("timeout wait cycles", k, TOUT - 1);
        check_lit("timeout change", int'(bus.change_value), 1);
        @(negedge clk_n);

        // Coin arriving during VEND is rejected.
        coin(0, 1);
        bus.price = 8'd2;
        bus.confirm = 1;
        @(negedge clk_n);
        check_lit("vend exact", int'(bus.vend), 1);
        bus.confirm = 0; bus.coin_one = 1;
        @(negedge clk_n);
        check_lit("coin in vend reject", int'(bus.reject), 1);
        check_lit("coin in vend no credit", int'(bus.coin_value), 0);
        bus.coin_one = 0;
        @(negedge clk_n);
        $display("txn coin during vend -> rejected");

        // Reset mid-transaction with coin_one held through release.
        coin(0, 1); coin(0, 1); coin(0, 1);
        check_lit("credit 6", int'(bus.coin_value), 6);
        rst = 0; bus.coin_one = 1;
        @(negedge clk_n);
        check_lit("rst coin_value", int'(bus.coin_value), 0);
        check_lit("rst no refund", int'(bus.refund), 0);
        check_lit("rst occupy", int'(bus.occupy), 0);
        rst = 1;
        repeat (3) @(negedge clk_n);
        check_lit("held coin no credit", int'(bus.coin_value), 0);
        bus.coin_one = 0;
        @(negedge clk_n);
        coin(0, 1);
        check_lit("after release credit", int'(bus.coin_value), 2);
        press(0, 1);
        repeat (2) @(negedge clk_n);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
